fofb_pos_err_stream: RTL and testbench
======================================

# fofb_pos_err_stream

Downstream stage of the BPM position reader in the fast-orbit-feedback path. It captures the X and Y position words written by the reader into two local position RAMs. On the reader's end-of-copy trigger it streams out position error, `pos - ref`, for every enabled entry: all X entries first, then all Y entries. Each error carries an index and a last flag for the matrix-multiply stage. The reference orbit and per-entry mask are loaded by the host through a separate write port.

## Interface
Parameters:
- `NPOS_MAX`, default 256: maximum entries per plane; also the depth of each plane RAM.
- `DATA_W`, default 32: width of signed position, reference and error words.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous active-high reset.
- `pos_x_wr`, in, 1: write enable, X position RAM.
- `pos_x_addr`, in, 9: X position RAM write address.
- `pos_y_wr`, in, 1: write enable, Y position RAM.
- `pos_y_addr`, in, 9: Y position RAM write address.
- `pos_data`, in, DATA_W: signed position word, shared by both planes.
- `ref_wr`, in, 1: host write enable, reference RAM.
- `ref_addr`, in, 10: host write address. Bit 9 selects Y (1) or X (0); bits 8:0 give the entry.
- `ref_data`, in, DATA_W: signed reference orbit word.
- `ref_mask_in`, in, 1: entry enable stored alongside `ref_data`.
- `start_trig`, in, 1: end-of-copy pulse from the position reader.
- `num_pos`, in, 9: entries per plane. Latched at start.
- `err_valid`, out, 1: error word valid.
- `err_data`, out, DATA_W: saturated signed error.
- `err_index`, out, 10: 0..n-1 for X, n..2n-1 for Y.
- `err_last`, out, 1: asserted with the final word of the stream.
- `busy`, out, 1: high from accepted start until `done`.
- `done`, out, 1: one-cycle pulse at end of stream.
- `overrun`, out, 1: sticky; set when `start_trig` arrives while busy.
- `sat_flag`, out, 1: sticky per stream; set when any error word saturated.

## Operation
- States: IDLE, RD_X, RD_Y, DRAIN, FIN.
- IDLE behaviour:
  - `start_trig` high with `num_pos` = 0: go to FIN.
  - `start_trig` high otherwise: latch `n = min(num_pos, NPOS_MAX)`, clear `sat_flag`, go to RD_X with read pointer 0.
- RD_X: issue one X read per cycle at addresses 0..n-1, then go to RD_Y.
- RD_Y: issue one Y read per cycle at addresses 0..n-1, then go to DRAIN.
- DRAIN: wait until the pipeline has emitted its last word, then go to FIN.
- FIN: pulse `done`, drop `busy`, return to IDLE.
- Each position read is paired with a reference read at the same plane and entry.
- Both RAMs are read-first: a write to the address being read in the same cycle returns the old word.
- Error arithmetic:
  - Compute `pos - ref` in DATA_W+1 bits.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - When clamping occurs, set `sat_flag`.
- Masked entries (stored mask = 0) still emit a word with `err_data` = 0 so indices stay aligned. A masked entry never sets `sat_flag`.
- `start_trig` while busy:
  - The start is ignored and `overrun` is set.
  - `overrun` clears only on `reset`.
- Position and reference writes are accepted in every state.

## Timing
- Reset values: `err_valid`, `err_data`, `err_index`, `err_last`, `busy`, `done`, `overrun` and `sat_flag` are all 0, and the state is IDLE. Reset does not clear RAM contents.
- Reset asserted mid-stream: outputs go to their reset values on the next edge and no further words are emitted.
- Start accepted at edge T (n > 0):
  - `busy` = 1 from T+1.
  - Read of X[0] is issued at T+1.
  - RAM data is available at T+2.
  - The registered error for index 0 appears at T+3.
- Output stream: `err_valid` is high for exactly 2n consecutive cycles, T+3..T+2+2n, with no gaps. `err_last` is high on cycle T+2+2n.
- End of stream: `done` pulses at T+3+2n, and `busy` is 0 from T+4+2n.
- A new start is accepted from cycle T+4+2n.
- `num_pos` = 0: `busy` is high at T+1, `done` pulses at T+1, and no words are emitted.
- `num_pos` > NPOS_MAX: clamped to NPOS_MAX, with the stream holding 2·NPOS_MAX words.
- `start_trig` on the same cycle as `done`: the start counts as overrun and is ignored.
- `sat_flag` updates in the same cycle as the saturated word's `err_valid`.

## Test plan
- Basic stream:
  - Stimulus: n=4, X positions 100..103, Y positions 200..203, refs all 10, mask all 1, start at T.
  - Response: 8 words 90,91,92,93,190..193 on cycles T+3..T+10; `err_index` 0..7; `err_last` at T+10; `done` at T+11.
- Masking:
  - Stimulus: mask X[1]=0 and Y[2]=0, otherwise as the basic stream.
  - Response: indices 1 and 6 carry 0; all 8 words are still emitted.
- Saturation:
  - Stimulus: X[0]=0x7FFFFFFF with ref -1, and Y[0]=0x80000000 with ref 1.
  - Response: outputs 0x7FFFFFFF and 0x80000000; `sat_flag`=1. A following clean stream clears `sat_flag`.
- Overrun:
  - Stimulus: a second `start_trig` at T+5 during an n=4 stream.
  - Response: the stream is unchanged, `overrun`=1 and stays set until `reset`.
- Boundaries:
  - `num_pos`=0: `done` at T+1 with no `err_valid`.
  - `num_pos`=300: exactly 512 words; the last word has `err_index`=511.
- Mid-stream reset:
  - Stimulus: `reset` at T+6 of an n=4 stream.
  - Response: all outputs 0 from T+7. The next start yields the full correct stream, showing RAM contents were retained.

Source files
------------

// File: rtl/fofb_pos_err_stream.sv
// Streams saturated position error (pos - ref) for every entry of the X then Y plane.
// Position and reference RAMs are read-first; reads and error math form a two-stage pipeline.
//   state   | meaning
//   IDLE    | waiting for start_trig
//   RD_X    | issuing X plane reads 0..n-1
//   RD_Y    | issuing Y plane reads 0..n-1
//   DRAIN   | waiting for the final word to leave the pipeline
//   FIN     | done pulse, then back to IDLE
module fofb_pos_err_stream #(
  parameter int NPOS_MAX = 256,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pos_x_wr,
  input  logic [8:0]        pos_x_addr,
  input  logic              pos_y_wr,
  input  logic [8:0]        pos_y_addr,
  input  logic [DATA_W-1:0] pos_data,
  input  logic              ref_wr,
  input  logic [9:0]        ref_addr,
  input  logic [DATA_W-1:0] ref_data,
  input  logic              ref_mask_in,
  input  logic              start_trig,
  input  logic [8:0]        num_pos,
  output logic              err_valid,
  output logic [DATA_W-1:0] err_data,
  output logic [9:0]        err_index,
  output logic              err_last,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              sat_flag
);

  localparam int         AW   = (NPOS_MAX > 1) ? $clog2(NPOS_MAX) : 1;
  localparam logic [9:0] NMAX = 10'(NPOS_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_X  = 3'd1;
  localparam logic [2:0] S_RD_Y  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [DATA_W-1:0] r_pos_x_mem [NPOS_MAX];
  logic [DATA_W-1:0] r_pos_y_mem [NPOS_MAX];
  logic [DATA_W-1:0] r_ref_mem   [2*NPOS_MAX];
  logic              r_mask_mem  [2*NPOS_MAX];

  logic [2:0]        r_state;
  logic [9:0]        r_rd_ptr;
  logic [9:0]        r_idx;
  logic [9:0]        r_n_last;
  logic [DATA_W-1:0] r_pos_x_q;
  logic [DATA_W-1:0] r_pos_y_q;
  logic [DATA_W-1:0] r_ref_q;
  logic              r_mask_q;
  logic              r_p1_valid;
  logic              r_p1_last;
  logic              r_p1_sel_y;
  logic [9:0]        r_p1_idx;
  logic              r_err_valid;
  logic [DATA_W-1:0] r_err_data;
  logic [9:0]        r_err_index;
  logic              r_err_last;
  logic              r_overrun;
  logic              r_sat_flag;

  logic              w_rd_en;
  logic              w_rd_last;
  logic [9:0]        w_n;
  logic [AW:0]       w_ref_rd_idx;
  logic [AW:0]       w_ref_wr_idx;
  logic [DATA_W-1:0] w_pos_sel;
  logic [DATA_W:0]   w_diff;
  logic              w_ovf;
  logic              w_sat;
  logic [DATA_W-1:0] w_err;

  assign w_rd_en      = (r_state == S_RD_X) || (r_state == S_RD_Y);
  assign w_rd_last    = (r_state == S_RD_Y) && (r_rd_ptr == r_n_last);
  assign w_n          = ({1'b0, num_pos} > NMAX) ? NMAX : {1'b0, num_pos};
  assign w_ref_rd_idx = {(r_state == S_RD_Y), r_rd_ptr[AW-1:0]};
  assign w_ref_wr_idx = {ref_addr[9], ref_addr[AW-1:0]};

  // Read-first RAMs: the registered read always sees the pre-write word.
  always_ff @(posedge clk) begin
    if (pos_x_wr && ({1'b0, pos_x_addr} < NMAX)) r_pos_x_mem[pos_x_addr[AW-1:0]] <= pos_data;
    r_pos_x_q <= r_pos_x_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (pos_y_wr && ({1'b0, pos_y_addr} < NMAX)) r_pos_y_mem[pos_y_addr[AW-1:0]] <= pos_data;
    r_pos_y_q <= r_pos_y_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (ref_wr && ({1'b0, ref_addr[8:0]} < NMAX)) begin
      r_ref_mem[w_ref_wr_idx]  <= ref_data;
      r_mask_mem[w_ref_wr_idx] <= ref_mask_in;
    end
    r_ref_q  <= r_ref_mem[w_ref_rd_idx];
    r_mask_q <= r_mask_mem[w_ref_rd_idx];
  end

  assign w_pos_sel = r_p1_sel_y ? r_pos_y_q : r_pos_x_q;
  assign w_diff    = {w_pos_sel[DATA_W-1], w_pos_sel} - {r_ref_q[DATA_W-1], r_ref_q};
  assign w_ovf     = w_diff[DATA_W] ^ w_diff[DATA_W-1];
  assign w_sat     = r_mask_q & w_ovf;

  always_comb begin
    w_err = w_diff[DATA_W-1:0];
    if (!r_mask_q)
      w_err = '0;
    else if (w_ovf)
      w_err = w_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_idx       <= '0;
      r_n_last    <= '0;
      r_p1_valid  <= 1'b0;
      r_p1_last   <= 1'b0;
      r_p1_sel_y  <= 1'b0;
      r_p1_idx    <= '0;
      r_err_valid <= 1'b0;
      r_err_data  <= '0;
      r_err_index <= '0;
      r_err_last  <= 1'b0;
      r_overrun   <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_p1_valid  <= w_rd_en;
      r_p1_last   <= w_rd_last;
      r_p1_sel_y  <= (r_state == S_RD_Y);
      r_p1_idx    <= r_idx;
      r_err_valid <= r_p1_valid;
      r_err_last  <= r_p1_valid & r_p1_last;
      r_err_index <= r_p1_valid ? r_p1_idx : '0;
      r_err_data  <= r_p1_valid ? w_err : '0;
      if (r_p1_valid && w_sat) r_sat_flag <= 1'b1;
      // FIN counts as busy, so a start coinciding with done is an overrun.
      if (start_trig && (r_state != S_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start_trig) begin
            if (num_pos == 9'd0) begin
              r_state <= S_FIN;
            end else begin
              r_n_last   <= w_n - 10'd1;
              r_rd_ptr   <= '0;
              r_idx      <= '0;
              r_sat_flag <= 1'b0;
              r_state    <= S_RD_X;
            end
          end
        end
        S_RD_X, S_RD_Y: begin
          r_idx    <= r_idx + 10'd1;
          r_rd_ptr <= r_rd_ptr + 10'd1;
          if (r_rd_ptr == r_n_last) begin
            r_rd_ptr <= '0;
            r_state  <= (r_state == S_RD_X) ? S_RD_Y : S_DRAIN;
          end
        end
        S_DRAIN: if (r_err_last) r_state <= S_FIN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign err_valid = r_err_valid;
  assign err_data  = r_err_data;
  assign err_index = r_err_index;
  assign err_last  = r_err_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign overrun   = r_overrun;
  assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_fofb_pos_err_stream.sv
// Scoreboard bench for fofb_pos_err_stream: a plain-arithmetic model predicts every
// error word and its cycle; a negedge monitor pops and compares what the DUT emits.
module tb_fofb_pos_err_stream;

  localparam int NP = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        pos_x_wr, pos_y_wr, ref_wr, ref_mask_in, start_trig;
  logic [8:0]  pos_x_addr, pos_y_addr, num_pos;
  logic [31:0] pos_data, ref_data;
  logic [9:0]  ref_addr;
  logic        err_valid, err_last, busy, done, overrun, sat_flag;
  logic [31:0] err_data;
  logic [9:0]  err_index;

  fofb_pos_err_stream #(.NPOS_MAX(NP), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .pos_x_wr(pos_x_wr), .pos_x_addr(pos_x_addr),
    .pos_y_wr(pos_y_wr), .pos_y_addr(pos_y_addr),
    .pos_data(pos_data),
    .ref_wr(ref_wr), .ref_addr(ref_addr), .ref_data(ref_data), .ref_mask_in(ref_mask_in),
    .start_trig(start_trig), .num_pos(num_pos),
    .err_valid(err_valid), .err_data(err_data), .err_index(err_index), .err_last(err_last),
    .busy(busy), .done(done), .overrun(overrun), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
    bit          sat;
    int          at;
  } exp_t;
  exp_t sb[$];

  // Reference image of the RAMs: plane 0 = X, 1 = Y.
  int m_pos [2][NP];
  int m_ref [2][NP];
  bit m_msk [2][NP];
  bit m_overrun = 0;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_err(int p, int r, bit m, output bit s);
    longint d;
    s = 0;
    if (!m) return 32'h0;
    d = longint'(p) - longint'(r);
    if (d > 64'sd2147483647)  begin s = 1; return 32'h7FFF_FFFF; end
    if (d < -64'sd2147483648) begin s = 1; return 32'h8000_0000; end
    return 32'(d);
  endfunction

  always @(negedge clk) begin
    if (err_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err_data", err_data, e.data);
        chk("err_index", err_index, e.idx);
        chk("err_last", err_last, e.last);
        chk("sat_flag", sat_flag, e.sat);
        chk("word_cycle", cyc, e.at);
      end
    end
  end

  task automatic wr_pos(int pl, int a, int d);
    pos_x_wr = (pl == 0); pos_y_wr = (pl == 1);
    pos_x_addr = 9'(a); pos_y_addr = 9'(a); pos_data = d;
    @(posedge clk); #1;
    pos_x_wr = 0; pos_y_wr = 0;
    m_pos[pl][a] = d;
  endtask

  task automatic wr_ref(int pl, int a, int d, bit m);
    ref_wr = 1; ref_addr = {pl[0], 9'(a)}; ref_data = d; ref_mask_in = m;
    @(posedge clk); #1;
    ref_wr = 0;
    m_ref[pl][a] = d; m_msk[pl][a] = m;
  endtask

  // Issue a start now and follow the stream to done; ovr_off > 0 re-pulses start that many cycles later.
  task automatic run_stream(int num, int ovr_off);
    int k0, n, got, exp_done;
    bit s, sat_acc;
    exp_t e;
    k0 = cyc;
    n = (num > NP) ? NP : num;
    sat_acc = 0;
    for (int k = 0; k < 2 * n; k++) begin
      int pl, a;
      pl = (k < n) ? 0 : 1;
      a  = (k < n) ? k : k - n;
      e.data = model_err(m_pos[pl][a], m_ref[pl][a], m_msk[pl][a], s);
      sat_acc = sat_acc | s;
      e.sat  = sat_acc;
      e.idx  = k;
      e.last = (k == 2 * n - 1);
      e.at   = k0 + 3 + k;
      sb.push_back(e);
    end
    exp_done = (n == 0) ? k0 + 1 : k0 + 3 + 2 * n;
    got = -1;
    num_pos = 9'(num);
    start_trig = 1;
    @(posedge clk); #1;
    start_trig = 0;
    for (int c = 1; c < 2 * n + 20; c++) begin
      if (c == ovr_off) begin start_trig = 1; m_overrun = 1; end
      @(negedge clk);
      if (done) begin
        got = cyc;
        chk("busy_at_done", busy, 1);
        break;
      end
      @(posedge clk); #1;
      start_trig = 0;
    end
    if (got < 0) chk("done_timeout", 0, 1);
    else chk("done_cycle", got, exp_done);
    @(posedge clk); #1;
    start_trig = 0;
    chk("busy_after_done", busy, 0);
    chk("words_left", sb.size(), 0);
    chk("sat_flag_end", sat_flag, (n == 0) ? 0 : sat_acc);
    chk("overrun", overrun, m_overrun);
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; pos_x_wr = 0; pos_y_wr = 0; ref_wr = 0; ref_mask_in = 0; start_trig = 0;
    pos_x_addr = 0; pos_y_addr = 0; num_pos = 0; pos_data = 0; ref_data = 0; ref_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", err_valid, 0); chk("rst_data", err_data, 0);
    chk("rst_index", err_index, 0); chk("rst_last", err_last, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0); chk("rst_sat", sat_flag, 0);
    reset = 0;
    @(posedge clk); #1;

    // Fill both planes completely so any stream length reads known data.
    for (int pl = 0; pl < 2; pl++)
      for (int a = 0; a < NP; a++) begin
        wr_pos(pl, a, int'($urandom_range(0, 2000000)) - 1000000);
        wr_ref(pl, a, int'($urandom_range(0, 2000000)) - 1000000, 1'b1);
      end

    // Basic stream
    for (int a = 0; a < 4; a++) begin
      wr_pos(0, a, 100 + a); wr_pos(1, a, 200 + a);
      wr_ref(0, a, 10, 1); wr_ref(1, a, 10, 1);
    end
    run_stream(4, 0);

    // Masking
    wr_ref(0, 1, 10, 0); wr_ref(1, 2, 10, 0);
    run_stream(4, 0);
    wr_ref(0, 1, 10, 1); wr_ref(1, 2, 10, 1);

    // Saturation, then a clean stream clears sat_flag
    wr_pos(0, 0, 32'h7FFF_FFFF); wr_ref(0, 0, -1, 1);
    wr_pos(1, 0, 32'h8000_0000); wr_ref(1, 0, 1, 1);
    run_stream(1, 0);
    wr_pos(0, 0, 100); wr_ref(0, 0, 10, 1);
    wr_pos(1, 0, 200); wr_ref(1, 0, 10, 1);
    run_stream(4, 0);

    // Overrun mid-stream and on the done cycle
    run_stream(4, 5);
    run_stream(4, 11);

    // Boundaries
    run_stream(0, 0);
    run_stream(300, 0);

    // Randomized streams with occasional full-range words that can saturate
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int a = 0; a < n; a++)
        for (int pl = 0; pl < 2; pl++) begin
          wr_pos(pl, a, ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 5000)));
          wr_ref(pl, a, ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 5000)),
                 $urandom_range(0, 4) != 0);
        end
      run_stream(n, 0);
    end

    // Mid-stream reset: words T+3..T+6 emitted, everything zero from T+7
    begin
      int k0;
      bit s;
      exp_t e;
      k0 = cyc;
      for (int k = 0; k < 4; k++) begin
        e.data = model_err(m_pos[0][k], m_ref[0][k], m_msk[0][k], s);
        e.idx = k; e.last = 0; e.at = k0 + 3 + k;
        e.sat = 0;
        for (int j = 0; j <= k; j++) begin
          bit sj;
          void'(model_err(m_pos[0][j], m_ref[0][j], m_msk[0][j], sj));
          e.sat = e.sat | sj;
        end
        sb.push_back(e);
      end
      num_pos = 9'd4;
      start_trig = 1;
      @(posedge clk); #1;
      start_trig = 0;
      while (cyc < k0 + 6) begin @(posedge clk); #1; end
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      m_overrun = 0;
      chk("mrst_valid", err_valid, 0); chk("mrst_busy", busy, 0);
      chk("mrst_index", err_index, 0); chk("mrst_data", err_data, 0);
      chk("mrst_last", err_last, 0);   chk("mrst_overrun", overrun, 0);
      chk("mrst_sat", sat_flag, 0);
      repeat (5) begin @(negedge clk); chk("mrst_quiet", err_valid, 0); end
      chk("mrst_words_seen", sb.size(), 0);
      sb.delete();
      @(posedge clk); #1;
      run_stream(4, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
